hpi_arbiter: RTL

HPI_ARBITER -- requirements
Module: hpi_arbiter

---
 rtl/hpi_pkg.sv | 21 ++
 rtl/hpi_rr_arbiter.sv | 36 +++
 rtl/hpi_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/hpi_pkg.sv
// Shared types and constants for the HPI arbiter: FSM states, phase counter
// type and HPI register-select codes.
package hpi_pkg;

   typedef enum logic [2:0] {
      ST_RESET   = 3'd0,
      ST_IDLE    = 3'd1,
      ST_SETUP   = 3'd2,
      ST_STROBE  = 3'd3,
      ST_HOLD    = 3'd4,
      ST_RECOVER = 3'd5
   } hpi_state_e;

   typedef logic [3:0] phase_cnt_t;

   localparam logic [1:0] HPI_DATA    = 2'd0;
   localparam logic [1:0] HPI_MAILBOX = 2'd1;
   localparam logic [1:0] HPI_ADDRESS = 2'd2;
   localparam logic [1:0] HPI_STATUS  = 2'd3;

endpackage

// File: rtl/hpi_rr_arbiter.sv
// Two-way round-robin selector; the last-granted pointer starts at 1 so
// requester 0 wins the first tie.
module hpi_rr_arbiter
   import hpi_pkg::*;
(
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic req0_i,
   input  logic req1_i,
   input  logic update_i,
   output logic any_o,
   output logic gnt_o
);

   logic last_q;
   logic last_d;

   always_comb begin
      any_o = req0_i | req1_i;
      if (req0_i && req1_i) begin
         gnt_o = ~last_q;
      end else begin
         gnt_o = req1_i;
      end
      last_d = update_i ? gnt_o : last_q;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/hpi_arbiter.sv
// Arbitrates two requesters onto the CY7C67200 HPI bus and sequences the
// setup/strobe/hold/recover timing plus the post-reset chip reset pulse.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RESET   | otg_hpi_reset_n low, counting RST_CYC; requests ignored
// ST_IDLE    | sample requests, latch winner's we/addr/wdata
// ST_SETUP   | cs_n low, address/data driven, strobes inactive
// ST_STROBE  | r_n or w_n low for STROBE_CYC cycles; read data captured last
// ST_HOLD    | strobes released, ack pulsed to the granted requester
// ST_RECOVER | bus idle for RECOVER_CYC cycles
module hpi_arbiter
   import hpi_pkg::*;
#(
   parameter int STROBE_CYC  = 4,
   parameter int RECOVER_CYC = 2,
   parameter int RST_CYC     = 16
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic        req0_req,
   input  logic        req1_req,
   input  logic        req0_we,
   input  logic        req1_we,
   input  logic [1:0]  req0_addr,
   input  logic [1:0]  req1_addr,
   input  logic [15:0] req0_wdata,
   input  logic [15:0] req1_wdata,
   output logic        req0_ack,
   output logic        req1_ack,
   output logic [15:0] req0_rdata,
   output logic [15:0] req1_rdata,
   output logic [1:0]  otg_hpi_address,
   output logic        otg_hpi_cs_n,
   output logic        otg_hpi_r_n,
   output logic        otg_hpi_w_n,
   output logic        otg_hpi_reset_n,
   output logic [15:0] otg_hpi_data_out,
   output logic        otg_hpi_data_oe,
   input  logic [15:0] otg_hpi_data_in
);

   localparam phase_cnt_t STROBE_LOAD  = phase_cnt_t'(STROBE_CYC - 1);
   localparam phase_cnt_t RECOVER_LOAD = phase_cnt_t'(RECOVER_CYC - 1);
   localparam logic [7:0] RST_LOAD     = 8'(RST_CYC);

   hpi_state_e  state_q, state_d;
   phase_cnt_t  phase_q, phase_d;
   logic [7:0]  rst_cnt_q, rst_cnt_d;
   logic [1:0]  rst_sync_q;
   logic        we_q, we_d;
   logic [1:0]  addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        gnt_q, gnt_d;
   logic        cs_n_q, cs_n_d;
   logic        r_n_q, r_n_d;
   logic        w_n_q, w_n_d;
   logic        oe_q, oe_d;
   logic        hpi_rst_n_q, hpi_rst_n_d;
   logic        ack0_q, ack0_d;
   logic        ack1_q, ack1_d;
   logic [15:0] rdata0_q, rdata0_d;
   logic [15:0] rdata1_q, rdata1_d;
   logic        rr_any;
   logic        rr_gnt;
   logic        rr_update;

   hpi_rr_arbiter u_rr (
      .clk_i    (clk_clk),
      .rst_n_i  (reset_reset_n),
      .req0_i   (req0_req),
      .req1_i   (req1_req),
      .update_i (rr_update),
      .any_o    (rr_any),
      .gnt_o    (rr_gnt)
   );

   // The release edge is only trusted once it has crossed two flops.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      rst_cnt_d = rst_cnt_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      gnt_d     = gnt_q;
      rr_update = 1'b0;
      ack0_d    = 1'b0;
      ack1_d    = 1'b0;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;

      case (state_q)
         ST_RESET: begin
            if (rst_cnt_q != 8'd0) begin
               rst_cnt_d = rst_cnt_q - 8'd1;
            end else if (rst_sync_q[1]) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (rr_any) begin
               state_d   = ST_SETUP;
               rr_update = 1'b1;
               gnt_d     = rr_gnt;
               we_d      = rr_gnt ? req1_we    : req0_we;
               addr_d    = rr_gnt ? req1_addr  : req0_addr;
               wdata_d   = rr_gnt ? req1_wdata : req0_wdata;
            end
         end
         ST_SETUP: begin
            state_d = ST_STROBE;
            phase_d = STROBE_LOAD;
         end
         ST_STROBE: begin
            if (phase_q == '0) begin
               state_d = ST_HOLD;
               // Registering here makes rdata valid in the ack cycle.
               if (!we_q) begin
                  if (gnt_q) rdata1_d = otg_hpi_data_in;
                  else       rdata0_d = otg_hpi_data_in;
               end
               if (gnt_q) ack1_d = 1'b1;
               else       ack0_d = 1'b1;
            end else begin
               phase_d = phase_q - phase_cnt_t'(1);
            end
         end
         ST_HOLD: begin
            state_d = ST_RECOVER;
            phase_d = RECOVER_LOAD;
         end
         ST_RECOVER: begin
            if (phase_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               phase_d = phase_q - phase_cnt_t'(1);
            end
         end
         default: state_d = ST_RESET;
      endcase

      // Bus controls are decoded from the next state so they leave a flop.
      cs_n_d      = !(state_d == ST_SETUP || state_d == ST_STROBE || state_d == ST_HOLD);
      r_n_d       = !(state_d == ST_STROBE && !we_d);
      w_n_d       = !(state_d == ST_STROBE && we_d);
      oe_d        = !cs_n_d && we_d;
      hpi_rst_n_d = (state_d != ST_RESET);
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q     <= ST_RESET;
         phase_q     <= '0;
         rst_cnt_q   <= RST_LOAD;
         we_q        <= 1'b0;
         addr_q      <= HPI_DATA;
         wdata_q     <= 16'h0000;
         gnt_q       <= 1'b0;
         cs_n_q      <= 1'b1;
         r_n_q       <= 1'b1;
         w_n_q       <= 1'b1;
         oe_q        <= 1'b0;
         hpi_rst_n_q <= 1'b0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         rdata0_q    <= 16'h0000;
         rdata1_q    <= 16'h0000;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         rst_cnt_q   <= rst_cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         gnt_q       <= gnt_d;
         cs_n_q      <= cs_n_d;
         r_n_q       <= r_n_d;
         w_n_q       <= w_n_d;
         oe_q        <= oe_d;
         hpi_rst_n_q <= hpi_rst_n_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
      end
   end

   assign otg_hpi_address  = addr_q;
   assign otg_hpi_data_out = wdata_q;
   assign otg_hpi_cs_n     = cs_n_q;
   assign otg_hpi_r_n      = r_n_q;
   assign otg_hpi_w_n      = w_n_q;
   assign otg_hpi_data_oe  = oe_q;
   assign otg_hpi_reset_n  = hpi_rst_n_q;
   assign req0_ack         = ack0_q;
   assign req1_ack         = ack1_q;
   assign req0_rdata       = rdata0_q;
   assign req1_rdata       = rdata1_q;

endmodule
